// File: rtl/apb_pkg.sv
// apb_pkg: state encoding and default bus widths shared by the
// round-robin APB master (apb_rr_master) and its arbiter.
package apb_pkg;

    localparam int APB_ADDR_WIDTH = 32;
    localparam int APB_DATA_WIDTH = 32;

    // APB transfer phases; psel/penable are decoded from these directly.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_t;

endpackage

// File: rtl/apb_rr_arb.sv
// apb_rr_arb: combinational N_REQ round-robin arbiter. The search starts
// one past last_grant (wrapping) so the most recent winner has lowest priority.
module apb_rr_arb #(
    parameter int N_REQ = 2,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    input  logic             enable,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic             found_s;
    logic [IDX_W-1:0] cand_s;

    // Rotating priority search: the first valid requester after last_grant wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        cand_s    = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand_s = IDX_W'((int'(last_grant) + off) % N_REQ);
            if (enable && !found_s && req[cand_s]) begin
                found_s       = 1'b1;
                grant[cand_s] = 1'b1;
                grant_idx     = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/apb_rr_master.sv
// apb_rr_master: round-robin APB master sharing one APB slave between N_REQ
// requesters. Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN;
// without it rsp_err is tied low and ACCESS waits for pready indefinitely.
module apb_rr_master
    import apb_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH = APB_DATA_WIDTH,
    parameter int TIMEOUT    = 16
) (
    input  logic                        pclk,
    input  logic                        presetn,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ-1:0]            req_write,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [N_REQ-1:0]            req_ready,
    output logic [N_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]       rsp_rdata,
    output logic                        rsp_err,
    output logic                        psel,
    output logic                        penable,
    output logic                        pwrite,
    output logic [ADDR_WIDTH-1:0]       paddr,
    output logic [DATA_WIDTH-1:0]       pwdata,
    input  logic [DATA_WIDTH-1:0]       prdata,
    input  logic                        pready
);

    localparam int IDX_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("apb_rr_master: N_REQ must be 2..8 and TIMEOUT at least 1");
    end

    apb_state_t            state_q, state_d;
    // Index of the requester owning the current transfer; doubles as the
    // round-robin pointer since both are updated on every grant.
    logic [IDX_W-1:0]      last_grant_q, last_grant_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [N_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic [N_REQ-1:0]      arb_grant_s;
    logic [IDX_W-1:0]      arb_idx_s;
    logic                  arb_en_s;

`ifdef APB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic                  rsp_err_q, rsp_err_d;
`endif

    // Requesters are only offered a grant while the bus is idle.
    assign arb_en_s = (state_q == IDLE);

    apb_rr_arb #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .enable     (arb_en_s),
        .grant      (arb_grant_s),
        .grant_idx  (arb_idx_s)
    );

    // Next-state logic: grant/latch in IDLE, one SETUP cycle, wait in ACCESS.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        rsp_valid_d  = '0;
        rsp_rdata_d  = rsp_rdata_q;
`ifdef APB_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
        rsp_err_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    state_d      = SETUP;
                    last_grant_d = arb_idx_s;
                    pwrite_d     = req_write[arb_idx_s];
                    paddr_d      = req_addr[int'(arb_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
                    pwdata_d     = req_wdata[int'(arb_idx_s)*DATA_WIDTH +: DATA_WIDTH];
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                state_d = ACCESS;
`ifdef APB_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            ACCESS: begin
                // pready is checked first so it wins on the last allowed cycle.
                if (pready) begin
                    state_d                   = IDLE;
                    rsp_valid_d[last_grant_q] = 1'b1;
                    if (!pwrite_q) begin
                        rsp_rdata_d = prdata;
                    end else begin
                        rsp_rdata_d = rsp_rdata_q;
                    end
                end
`ifdef APB_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
                    state_d                   = IDLE;
                    rsp_valid_d[last_grant_q] = 1'b1;
                    rsp_rdata_d               = '0;
                    rsp_err_d                 = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
`else
                else begin
                    state_d = ACCESS;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any in-flight transfer.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q      <= IDLE;
            last_grant_q <= IDX_W'(N_REQ - 1);
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
`ifdef APB_TIMEOUT_EN
            tmo_cnt_q    <= '0;
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
`ifdef APB_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
            rsp_err_q    <= rsp_err_d;
`endif
        end
    end

    assign req_ready = arb_grant_s;
    assign psel      = (state_q == SETUP) || (state_q == ACCESS);
    assign penable   = (state_q == ACCESS);
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
`ifdef APB_TIMEOUT_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_apb_rr_master.sv
// tb_apb_rr_master: directed and randomized checks of apb_rr_master (N_REQ=2)
// against a transaction-level model: rotating grant pick, 4-word slave memory.
module tb_apb_rr_master;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            pclk = 1'b0;
    logic            presetn;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            psel;
    logic            penable;
    logic            pwrite;
    logic [AW-1:0]   paddr;
    logic [DW-1:0]   pwdata;
    logic [DW-1:0]   prdata;
    logic            pready;

    // Bench-side slave: 4-word RAM, or a directly driven prdata value.
    logic            slave_auto;
    logic [DW-1:0]   prdata_drv;
    logic [DW-1:0]   slv_mem [4] = '{32'h0, 32'h0, 32'h0, 32'h0};

    // Reference model state.
    logic [DW-1:0]   ref_mem [4];
    logic            c_wr   [N];
    logic [AW-1:0]   c_addr [N];
    logic [DW-1:0]   c_wd   [N];
    logic [DW-1:0]   exp_rdata;
    int              last_g;
    int              checks = 0;
    int              errors = 0;

    apb_rr_master #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(16)) dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready)
    );

    always #5 pclk = ~pclk;

    assign prdata = slave_auto ? slv_mem[paddr[1:0]] : prdata_drv;

    always @(posedge pclk) begin
        if (psel && penable && pready && pwrite) slv_mem[paddr[1:0]] <= pwdata;
    end

    // Round-robin rule: first valid requester after the last winner, wrapping.
    function automatic int pick(input logic [N-1:0] m, input int last);
        for (int k = 1; k <= N; k++) begin
            if (m[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] v;
        v = '0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    task automatic apply_cmd(input int i);
        req_write[i]          = c_wr[i];
        req_addr[i*AW +: AW]  = c_addr[i];
        req_wdata[i*DW +: DW] = c_wd[i];
    endtask

    task automatic set_cmd(input int i);
        c_wr[i]   = 1'($urandom_range(0, 1));
        c_addr[i] = $urandom;
        c_wd[i]   = $urandom;
        apply_cmd(i);
    endtask

    // Effect of a completed transfer on slave memory / expected read data.
    task automatic model_complete(input int g);
        if (c_wr[g]) ref_mem[c_addr[g][1:0]] = c_wd[g];
        else         exp_rdata = ref_mem[c_addr[g][1:0]];
    endtask

    task automatic apply_reset();
        presetn   = 1'b0;
        req_valid = '0;
        pready    = 1'b0;
        repeat (2) @(negedge pclk);
        presetn   = 1'b1;
        last_g    = N - 1;
        exp_rdata = '0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++;
        if ({psel, penable, pwrite, rsp_err} !== 4'b0000 || paddr !== '0 || pwdata !== '0)
            $display("FAIL reset_bus: psel/pen/pwrite/err=%b%b%b%b paddr=%h pwdata=%h expected all 0",
                     psel, penable, pwrite, rsp_err, paddr, pwdata);
        if ({psel, penable, pwrite, rsp_err} !== 4'b0000 || paddr !== '0 || pwdata !== '0) errors++;
        checks++;
        if (rsp_valid !== '0 || rsp_rdata !== '0 || req_ready !== '0) begin
            errors++;
            $display("FAIL reset_rsp: rsp_valid=%b rsp_rdata=%h req_ready=%b expected 0", rsp_valid, rsp_rdata, req_ready);
        end
        @(negedge pclk);
    endtask

    task automatic test_write_no_wait();
        slave_auto = 1'b0; prdata_drv = $urandom;
        c_wr[0] = 1'b1; c_addr[0] = 32'd2; c_wd[0] = 32'hDEADBEEF; apply_cmd(0);
        req_valid = 2'b01; pready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL wr_ready: got %b expected 01", req_ready); end
        model_complete(0); last_g = 0;
        @(negedge pclk); req_valid = '0; #1;
        checks++;
        if ({psel, penable, pwrite} !== 3'b101 || paddr !== 32'd2 || pwdata !== 32'hDEADBEEF || rsp_valid !== '0) begin
            errors++;
            $display("FAIL wr_setup: psel/pen/pwrite=%b%b%b paddr=%h pwdata=%h rsp_valid=%b expected 101 2 deadbeef 00",
                     psel, penable, pwrite, paddr, pwdata, rsp_valid);
        end
        @(negedge pclk); #1;
        checks++;
        if ({psel, penable} !== 2'b11 || paddr !== 32'd2) begin
            errors++; $display("FAIL wr_access: psel/pen=%b%b paddr=%h expected 11 2", psel, penable, paddr);
        end
        @(negedge pclk); pready = 1'b0; #1;
        checks++;
        if (rsp_valid !== 2'b01 || rsp_err !== 1'b0 || rsp_rdata !== exp_rdata || psel !== 1'b0) begin
            errors++;
            $display("FAIL wr_rsp: rsp_valid=%b err=%b rdata=%h psel=%b expected 01 0 %h 0", rsp_valid, rsp_err, rsp_rdata, psel, exp_rdata);
        end
        @(negedge pclk); #1;
        checks++;
        if (rsp_valid !== '0) begin errors++; $display("FAIL wr_rsp_pulse: got %b expected 00", rsp_valid); end
        @(negedge pclk);
    endtask

    task automatic test_read_wait();
        slave_auto = 1'b0;
        c_wr[1] = 1'b0; c_addr[1] = 32'd1; c_wd[1] = $urandom; apply_cmd(1);
        req_valid = 2'b10; pready = 1'b0;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin errors++; $display("FAIL rd_ready: got %b expected 10", req_ready); end
        last_g = 1; exp_rdata = 32'h12345678;
        @(negedge pclk); req_valid = '0; #1;
        checks++;
        if ({psel, penable, pwrite} !== 3'b100 || paddr !== 32'd1) begin
            errors++; $display("FAIL rd_setup: psel/pen/pwrite=%b%b%b paddr=%h expected 100 1", psel, penable, pwrite, paddr);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge pclk);
            pready     = (k == 3);
            prdata_drv = (k == 3) ? 32'h12345678 : $urandom;
            #1;
            checks++;
            if ({psel, penable} !== 2'b11 || rsp_valid !== '0) begin
                errors++; $display("FAIL rd_wait%0d: psel/pen=%b%b rsp_valid=%b expected 11 00", k, psel, penable, rsp_valid);
            end
        end
        @(negedge pclk); pready = 1'b0; #1;
        checks++;
        if (rsp_valid !== 2'b10 || rsp_rdata !== 32'h12345678 || rsp_err !== 1'b0 || psel !== 1'b0) begin
            errors++;
            $display("FAIL rd_rsp: rsp_valid=%b rdata=%h err=%b psel=%b expected 10 12345678 0 0", rsp_valid, rsp_rdata, rsp_err, psel);
        end
        @(negedge pclk);
    endtask

    task automatic test_contention();
        int g;
        int prev;
        apply_reset();
        slave_auto = 1'b1; pready = 1'b1;
        for (int i = 0; i < N; i++) set_cmd(i);
        req_valid = '1;
        prev = -1;
        for (int t = 0; t < 6; t++) begin
            #1;
            if (prev >= 0) begin
                checks++;
                if (rsp_valid !== onehot(prev) || rsp_err !== 1'b0 || rsp_rdata !== exp_rdata) begin
                    errors++;
                    $display("FAIL cont_rsp%0d: rsp_valid=%b rdata=%h err=%b expected %b %h 0", t, rsp_valid, rsp_rdata, rsp_err, onehot(prev), exp_rdata);
                end
            end
            g = t % N;
            checks++;
            if (req_ready !== onehot(g)) begin
                errors++; $display("FAIL cont_grant%0d: req_ready=%b expected %b", t, req_ready, onehot(g));
            end
            model_complete(g); last_g = g; prev = g;
            @(negedge pclk); set_cmd(g); #1;
            checks++;
            if ({psel, penable} !== 2'b10 || req_ready !== '0) begin
                errors++; $display("FAIL cont_setup%0d: psel/pen=%b%b req_ready=%b expected 10 00", t, psel, penable, req_ready);
            end
            @(negedge pclk); #1;
            checks++;
            if ({psel, penable} !== 2'b11 || req_ready !== '0) begin
                errors++; $display("FAIL cont_access%0d: psel/pen=%b%b req_ready=%b expected 11 00", t, psel, penable, req_ready);
            end
            @(negedge pclk);
        end
        req_valid = '0; #1;
        checks++;
        if (rsp_valid !== onehot(prev) || rsp_rdata !== exp_rdata) begin
            errors++; $display("FAIL cont_last_rsp: rsp_valid=%b rdata=%h expected %b %h", rsp_valid, rsp_rdata, onehot(prev), exp_rdata);
        end
        @(negedge pclk);
    endtask

    task automatic test_lone();
        apply_reset();
        slave_auto = 1'b1; pready = 1'b1;
        set_cmd(1); req_valid = 2'b10;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin errors++; $display("FAIL lone_grant: req_ready=%b expected 10", req_ready); end
        model_complete(1); last_g = 1;
        @(negedge pclk); req_valid = '0; #1;
        checks++;
        if ({psel, penable} !== 2'b10 || paddr !== c_addr[1]) begin
            errors++; $display("FAIL lone_setup: psel/pen=%b%b paddr=%h expected 10 %h", psel, penable, paddr, c_addr[1]);
        end
        repeat (2) @(negedge pclk);
        #1;
        checks++;
        if (rsp_valid !== 2'b10 || rsp_rdata !== exp_rdata) begin
            errors++; $display("FAIL lone_rsp: rsp_valid=%b rdata=%h expected 10 %h", rsp_valid, rsp_rdata, exp_rdata);
        end
        set_cmd(0); set_cmd(1); req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL lone_pointer: req_ready=%b expected 01", req_ready); end
        model_complete(0); last_g = 0;
        @(negedge pclk); req_valid = '0;
        repeat (2) @(negedge pclk);
        #1;
        checks++;
        if (rsp_valid !== 2'b01 || rsp_rdata !== exp_rdata) begin
            errors++; $display("FAIL lone_rsp2: rsp_valid=%b rdata=%h expected 01 %h", rsp_valid, rsp_rdata, exp_rdata);
        end
        @(negedge pclk);
    endtask

    task automatic test_reset_mid();
        slave_auto = 1'b1; pready = 1'b0;
        set_cmd(1); req_valid = 2'b10;
        #1;
        checks++;
        if (req_ready !== onehot(pick(2'b10, last_g))) begin
            errors++; $display("FAIL rst_mid_grant: req_ready=%b expected 10", req_ready);
        end
        @(negedge pclk); req_valid = '0;
        @(negedge pclk); #1;
        checks++;
        if ({psel, penable} !== 2'b11) begin errors++; $display("FAIL rst_mid_access: psel/pen=%b%b expected 11", psel, penable); end
        #2 presetn = 1'b0;
        #1;
        checks++;
        if ({psel, penable} !== 2'b00) begin errors++; $display("FAIL rst_mid_async: psel/pen=%b%b expected 00", psel, penable); end
        @(negedge pclk);
        presetn = 1'b1; last_g = N - 1; exp_rdata = '0; pready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (rsp_valid !== '0 || psel !== 1'b0) begin
                errors++; $display("FAIL rst_mid_quiet%0d: rsp_valid=%b psel=%b expected 00 0", k, rsp_valid, psel);
            end
            @(negedge pclk);
        end
        set_cmd(0); set_cmd(1); req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL rst_mid_first: req_ready=%b expected 01", req_ready); end
        model_complete(0); last_g = 0;
        @(negedge pclk); req_valid = '0;
        repeat (2) @(negedge pclk);
        #1;
        checks++;
        if (rsp_valid !== 2'b01 || rsp_rdata !== exp_rdata) begin
            errors++; $display("FAIL rst_mid_rsp: rsp_valid=%b rdata=%h expected 01 %h", rsp_valid, rsp_rdata, exp_rdata);
        end
        @(negedge pclk);
    endtask

    task automatic test_random();
        int           g;
        int           w;
        int           n_done;
        logic [N-1:0] rsp_exp;
        slave_auto = 1'b1;
        req_valid  = '0;
        rsp_exp    = '0;
        n_done     = 0;
        while (n_done < 40) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    set_cmd(i); req_valid[i] = 1'b1;
                end
            end
            pready = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (rsp_valid !== rsp_exp || (rsp_exp !== '0 && (rsp_rdata !== exp_rdata || rsp_err !== 1'b0))) begin
                errors++;
                $display("FAIL rnd_rsp%0d: rsp_valid=%b rdata=%h err=%b expected %b %h 0", n_done, rsp_valid, rsp_rdata, rsp_err, rsp_exp, exp_rdata);
            end
            rsp_exp = '0;
            g = pick(req_valid, last_g);
            checks++;
            if (req_ready !== onehot(g)) begin
                errors++; $display("FAIL rnd_grant%0d: req_ready=%b expected %b", n_done, req_ready, onehot(g));
            end
            if (g < 0) begin
                @(negedge pclk);
                continue;
            end
            model_complete(g); last_g = g;
            @(negedge pclk); req_valid[g] = 1'b0; pready = 1'($urandom_range(0, 1)); #1;
            checks++;
            if ({psel, penable, pwrite} !== {1'b1, 1'b0, c_wr[g]} || paddr !== c_addr[g] || pwdata !== c_wd[g]) begin
                errors++;
                $display("FAIL rnd_setup%0d: psel/pen/pwrite=%b%b%b paddr=%h pwdata=%h expected 10%b %h %h",
                         n_done, psel, penable, pwrite, paddr, pwdata, c_wr[g], c_addr[g], c_wd[g]);
            end
            w = $urandom_range(0, 3);
            for (int k = 0; k <= w; k++) begin
                @(negedge pclk); pready = (k == w); #1;
                checks++;
                if ({psel, penable} !== 2'b11 || paddr !== c_addr[g] || rsp_valid !== '0) begin
                    errors++;
                    $display("FAIL rnd_access%0d: psel/pen=%b%b paddr=%h rsp_valid=%b expected 11 %h 00", n_done, psel, penable, paddr, rsp_valid, c_addr[g]);
                end
            end
            rsp_exp = onehot(g);
            n_done++;
            @(negedge pclk);
        end
        req_valid = '0; pready = 1'b0; #1;
        checks++;
        if (rsp_valid !== rsp_exp || rsp_rdata !== exp_rdata) begin
            errors++; $display("FAIL rnd_last_rsp: rsp_valid=%b rdata=%h expected %b %h", rsp_valid, rsp_rdata, rsp_exp, exp_rdata);
        end
        @(negedge pclk);
    endtask

`ifdef APB_TIMEOUT_EN
    task automatic test_timeout();
        slave_auto = 1'b1;
        for (int r = 0; r < 2; r++) begin
            set_cmd(0); req_valid = 2'b01; pready = 1'b0;
            #1;
            checks++;
            if (req_ready !== 2'b01) begin errors++; $display("FAIL tmo_grant%0d: req_ready=%b expected 01", r, req_ready); end
            if (r == 1) model_complete(0);
            last_g = 0;
            @(negedge pclk); req_valid = '0;
            for (int k = 0; k < 16; k++) begin
                @(negedge pclk); pready = (r == 1 && k == 15); #1;
                checks++;
                if ({psel, penable} !== 2'b11 || rsp_valid !== '0) begin
                    errors++; $display("FAIL tmo_wait%0d_%0d: psel/pen=%b%b rsp_valid=%b expected 11 00", r, k, psel, penable, rsp_valid);
                end
            end
            @(negedge pclk); pready = 1'b0; #1;
            if (r == 0) exp_rdata = '0;
            checks++;
            if (rsp_valid !== 2'b01 || rsp_err !== (r == 0) || rsp_rdata !== exp_rdata || psel !== 1'b0) begin
                errors++;
                $display("FAIL tmo_rsp%0d: rsp_valid=%b err=%b rdata=%h psel=%b expected 01 %0d %h 0", r, rsp_valid, rsp_err, rsp_rdata, psel, (r == 0), exp_rdata);
            end
            @(negedge pclk);
        end
    endtask
`endif

    initial begin
        presetn    = 1'b0;
        req_valid  = '0;
        req_write  = '0;
        req_addr   = '0;
        req_wdata  = '0;
        pready     = 1'b0;
        slave_auto = 1'b1;
        prdata_drv = '0;
        exp_rdata  = '0;
        last_g     = N - 1;
        for (int i = 0; i < 4; i++) ref_mem[i] = '0;
        test_reset();
        test_write_no_wait();
        test_read_wait();
        test_contention();
        test_lone();
        test_reset_mid();
        test_random();
`ifdef APB_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
